// File: rtl/regs_wb.sv
// Write-back arbiter for the integer register file: ex results get the port
// every cycle they are active, lu results queue in a small FIFO behind them.
module regs_wb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lu_issue_i,
    input  logic [4:0]  lu_issue_addr_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_waddr_i,
    input  logic [31:0] lu_wdata_i,
    output logic        lu_ready_o,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    output logic        stall_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [31:0]     pend;
    logic [31:0]     pend_next;

    logic ex_active;
    logic do_pop;
    logic do_push;

    assign head      = fifo_mem[rd_ptr];
    assign ex_active = ex_wen_i && (ex_waddr_i != 5'd0);

    // Ready comes from the registered count, so a pop this cycle frees a slot
    // only from the next cycle on.
    assign lu_ready_o = rst && (count < FULL_CNT);
    assign do_pop     = rst && !ex_active && (count != '0);
    // Results for x0 are acknowledged but never stored.
    assign do_push    = lu_valid_i && lu_ready_o && (lu_waddr_i != 5'd0);

    // pend[0] is never set, so index 0 contributes nothing to the stall.
    assign stall_o = rst && (pend[id_rs1_i] || pend[id_rs2_i] || pend[id_rd_i]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned and infers a latch.
        reg_wen_o   = 1'b0;
        reg_waddr_o = 5'd0;
        reg_wdata_o = 32'd0;
        if (rst) begin
            if (ex_active) begin
                reg_wen_o   = 1'b1;
                reg_waddr_o = ex_waddr_i;
                reg_wdata_o = ex_wdata_i;
            end else if (do_pop) begin
                reg_wen_o   = 1'b1;
                reg_waddr_o = head.addr;
                reg_wdata_o = head.data;
            end
        end
    end

    always_comb begin
        pend_next = pend;
        if (do_pop)
            pend_next[head.addr] = 1'b0;
        // Set is applied after clear so a same-address issue wins.
        if (lu_issue_i && (lu_issue_addr_i != 5'd0))
            pend_next[lu_issue_addr_i] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // NOTE: the FIFO storage is deliberately not reset; count and the pointers
    // decide what is valid, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr] <= '{addr: lu_waddr_i, data: lu_wdata_i};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pend <= pend_next;
        end
    end

endmodule

// File: tb/tb_regs_wb.sv
// Directed self-checking bench for regs_wb: inputs change 1 ns after the
// rising edge, outputs are checked 3 ns after it.
module tb_regs_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wen_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lu_issue_i;
    logic [4:0]  lu_issue_addr_i;
    logic        lu_valid_i;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        lu_ready_o;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        stall_o;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int n_tests = 0;
    int n_fail  = 0;

    regs_wb #(.DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_wen_i        (ex_wen_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_wdata_i      (ex_wdata_i),
        .lu_issue_i      (lu_issue_i),
        .lu_issue_addr_i (lu_issue_addr_i),
        .lu_valid_i      (lu_valid_i),
        .lu_waddr_i      (lu_waddr_i),
        .lu_wdata_i      (lu_wdata_i),
        .lu_ready_o      (lu_ready_o),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_rd_i         (id_rd_i),
        .stall_o         (stall_o),
        .reg_wen_o       (reg_wen_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_wr(input string tag, input logic wen, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, ".wen"},   64'(reg_wen_o),   64'(wen));
        check({tag, ".addr"},  64'(reg_waddr_o), 64'(addr));
        check({tag, ".data"},  64'(reg_wdata_o), 64'(data));
    endtask

    task automatic ex(input logic en, input logic [4:0] a, input logic [31:0] d);
        ex_wen_i = en; ex_waddr_i = a; ex_wdata_i = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid_i = v; lu_waddr_i = a; lu_wdata_i = d;
    endtask

    task automatic issue(input logic en, input logic [4:0] a);
        lu_issue_i = en; lu_issue_addr_i = a;
    endtask

    initial begin
        rst = 1'b0;
        ex(1'b0, 5'd0, 32'd0);
        lu(1'b0, 5'd0, 32'd0);
        issue(1'b0, 5'd0);
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;

        // Reset held two cycles with traffic on the inputs
        #1;
        ex(1'b1, 5'd5, 32'hCAFE_0001);
        lu(1'b1, 5'd6, 32'hCAFE_0002);
        issue(1'b1, 5'd6);
        id_rs1_i = 5'd6;
        step();
        step();
        settle();
        check_wr("rst_out", 1'b0, 5'd0, 32'd0);
        check("rst_ready", 64'(lu_ready_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        step();
        rst = 1'b1;
        ex(1'b0, 5'd0, 32'd0);
        lu(1'b0, 5'd0, 32'd0);
        issue(1'b0, 5'd0);
        settle();
        check("post_rst_ready", 64'(lu_ready_o), 64'd1);
        check("post_rst_stall", 64'(stall_o), 64'd0);
        check("post_rst_wen", 64'(reg_wen_o), 64'd0);

        // Ex passthrough, then an ex write to x0
        step();
        ex(1'b1, 5'd5, 32'hDEAD_BEEF);
        settle();
        check_wr("ex_pass", 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        ex(1'b1, 5'd0, 32'h1111_2222);
        settle();
        check_wr("ex_x0", 1'b0, 5'd0, 32'd0);

        // Lu issue to x7 raises stall, result retires one cycle after the push
        step();
        ex(1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd7);
        step();
        issue(1'b0, 5'd0);
        id_rs2_i = 5'd7;
        lu(1'b1, 5'd7, 32'h1234_5678);
        settle();
        check("x7_stall_set", 64'(stall_o), 64'd1);
        check("x7_wen_before", 64'(reg_wen_o), 64'd0);
        step();
        lu(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("x7_write", 1'b1, 5'd7, 32'h1234_5678);
        check("x7_stall_popcyc", 64'(stall_o), 64'd1);
        step();
        settle();
        check("x7_stall_clr", 64'(stall_o), 64'd0);
        check("x7_idle_wen", 64'(reg_wen_o), 64'd0);
        id_rs2_i = 5'd0;

        // Lu result for x0 is accepted but never written
        step();
        lu(1'b1, 5'd0, 32'hBAD0_0000);
        settle();
        check("x0_lu_ready", 64'(lu_ready_o), 64'd1);
        step();
        lu(1'b0, 5'd0, 32'd0);
        settle();
        check("x0_lu_nowrite", 64'(reg_wen_o), 64'd0);

        // Ex busy every cycle while two lu results fill the FIFO
        step();
        ex(1'b1, 5'd10, 32'h0000_AAAA);
        issue(1'b1, 5'd3);
        lu(1'b1, 5'd3, 32'h1);
        settle();
        check("fill1_ready", 64'(lu_ready_o), 64'd1);
        step();
        issue(1'b1, 5'd4);
        lu(1'b1, 5'd4, 32'h2);
        settle();
        check_wr("fill2_ex_wins", 1'b1, 5'd10, 32'h0000_AAAA);
        check("fill2_ready", 64'(lu_ready_o), 64'd1);
        step();
        issue(1'b0, 5'd0);
        lu(1'b1, 5'd5, 32'h3);
        id_rs1_i = 5'd3;
        settle();
        check("full_ready", 64'(lu_ready_o), 64'd0);
        check("full_ex_addr", 64'(reg_waddr_o), 64'd10);
        check("full_stall_x3", 64'(stall_o), 64'd1);
        step();
        settle();
        check("full_held_ready", 64'(lu_ready_o), 64'd0);
        step();
        ex(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("drain_x3", 1'b1, 5'd3, 32'h1);
        check("drain_ready_same", 64'(lu_ready_o), 64'd0);
        step();
        settle();
        check_wr("drain_x4", 1'b1, 5'd4, 32'h2);
        check("drain_ready_next", 64'(lu_ready_o), 64'd1);
        check("drain_stall_x3", 64'(stall_o), 64'd0);
        // The held x5 result is pushed while x4 pops: count must stay at 1
        step();
        lu(1'b0, 5'd0, 32'd0);
        id_rs1_i = 5'd0;
        settle();
        check_wr("pushpop_x5", 1'b1, 5'd5, 32'h3);
        check("pushpop_ready", 64'(lu_ready_o), 64'd1);
        step();
        settle();
        check("pushpop_empty", 64'(reg_wen_o), 64'd0);

        // Pop of x9 coincides with a new issue to x9, with an ex write to x0
        issue(1'b1, 5'd9);
        step();
        issue(1'b0, 5'd0);
        lu(1'b1, 5'd9, 32'h99);
        step();
        lu(1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd9);
        ex(1'b1, 5'd0, 32'hFFFF_FFFF);
        settle();
        check_wr("x9_pop", 1'b1, 5'd9, 32'h99);
        step();
        issue(1'b0, 5'd0);
        ex(1'b0, 5'd0, 32'd0);
        id_rs1_i = 5'd9;
        lu(1'b1, 5'd9, 32'h77);
        settle();
        check("x9_set_wins", 64'(stall_o), 64'd1);
        step();
        lu(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("x9_second", 1'b1, 5'd9, 32'h77);
        step();
        settle();
        check("x9_stall_clr", 64'(stall_o), 64'd0);
        id_rs1_i = 5'd0;

        // Reset with two entries buffered and x3/x4 pending
        step();
        ex(1'b1, 5'd1, 32'h5555);
        issue(1'b1, 5'd3);
        lu(1'b1, 5'd3, 32'hA3);
        step();
        issue(1'b1, 5'd4);
        lu(1'b1, 5'd4, 32'hA4);
        step();
        issue(1'b0, 5'd0);
        lu(1'b0, 5'd0, 32'd0);
        id_rs1_i = 5'd3;
        id_rd_i  = 5'd4;
        settle();
        check("mid_pend", 64'(stall_o), 64'd1);
        id_rs1_i = 5'd0;
        settle();
        check("mid_pend_rd", 64'(stall_o), 64'd1);
        step();
        rst = 1'b0;
        ex(1'b0, 5'd0, 32'd0);
        settle();
        check("mid_rst_wen", 64'(reg_wen_o), 64'd0);
        step();
        rst = 1'b1;
        id_rs1_i = 5'd3;
        settle();
        check("mid_after_wen", 64'(reg_wen_o), 64'd0);
        check("mid_after_stall", 64'(stall_o), 64'd0);
        check("mid_after_ready", 64'(lu_ready_o), 64'd1);
        step();
        settle();
        check("mid_after_wen2", 64'(reg_wen_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regs_wb.md
# regs_wb

Write-back arbiter and scoreboard that drives the single write port of the 32×32 integer register file. Single-cycle results from ex and results from a long-latency unit (lu, e.g. divider or load) share that port. Ex always wins the port. Lu results wait in a small FIFO until the port is free. A per-register pending scoreboard raises `stall_o` to id while a register has an outstanding lu write.

## Interface
Parameters:
- DEPTH, 2 — lu result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ex_wen_i  in  1  ex result valid this cycle
- ex_waddr_i  in  5  ex destination register
- ex_wdata_i  in  32  ex result
- lu_issue_i  in  1  id issues a lu op this cycle
- lu_issue_addr_i  in  5  destination register of the issued lu op
- lu_valid_i  in  1  lu result valid
- lu_waddr_i  in  5  lu result destination
- lu_wdata_i  in  32  lu result
- lu_ready_o  out  1  FIFO can accept a lu result
- id_rs1_i  in  5  id source register 1
- id_rs2_i  in  5  id source register 2
- id_rd_i  in  5  id destination register (WAW check)
- stall_o  out  1  id must hold its instruction
- reg_wen_o  out  1  register file write enable
- reg_waddr_o  out  5  register file write address
- reg_wdata_o  out  32  register file write data

## Operation
State:
- FIFO: DEPTH entries of {addr[4:0], data[31:0]}, with rd_ptr, wr_ptr, and count[log2(DEPTH):0].
- pend[31:1]: scoreboard bits. x0 is never pending.

Port arbitration (combinational, same cycle):
- ex_active = ex_wen_i && ex_waddr_i != 0. When ex_active, the output carries the ex write: wen=1, addr=ex_waddr_i, data=ex_wdata_i.
- Otherwise, if count>0, the output carries the FIFO head: wen=1, FIFO pops, and pend[head.addr] clears.
- Otherwise reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
- An ex write to x0 is dropped and does not block the FIFO that cycle.

Lu handshake:
- lu_ready_o = (count < DEPTH). It is derived from registered count, so a pop in the current cycle does not raise ready in that cycle.
- A push happens when lu_valid_i && lu_ready_o. A result addressed to x0 is accepted but not stored.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- The FIFO preserves order; lu results retire in arrival order.

Scoreboard:
- lu_issue_i with lu_issue_addr_i != 0 sets pend[addr] at the clock edge.
- If a set and a clear target the same address in the same cycle, set wins.
- Issuing to an address that is already pending leaves a single bit set. id prevents this case through stall_o.
- stall_o = pend[id_rs1_i] | pend[id_rs2_i] | pend[id_rd_i], where any index of 0 contributes 0. It is combinational from registered pend; a clear takes effect the cycle after the pop.

Reset (rst==0 at a clock edge):
- count, rd_ptr and wr_ptr go to 0; pend goes to all 0.
- While rst==0, all outputs are forced to 0: lu_ready_o=0, stall_o=0, reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
- A reset mid-operation discards buffered lu results without writing them.

## Timing
- Ex path: zero latency. ex inputs appear on reg_* in the same cycle; the register file's write-through covers same-cycle reads.
- Lu path:
  - Minimum latency is 1 cycle: a push at edge N makes the entry the head, written in cycle N+1 if ex is idle.
  - With continuous ex_active, lu entries wait indefinitely. Starvation is acceptable because ex is bounded by id stalls.
- Stall release: the pop cycle writes the register (visible through write-through); stall_o drops the next cycle.
- Full: while count==DEPTH, lu_ready_o=0 and lu must hold lu_valid_i and its data stable until ready.
- Empty with ex idle: reg_wen_o=0.

## Test plan
- Reset: hold rst=0 for 2 cycles while driving lu_valid_i=1 and ex_wen_i=1 -> all outputs 0; after release, lu_ready_o=1 and stall_o=0.
- Ex passthrough: ex_wen_i=1, addr=5, data=0xDEADBEEF -> same cycle reg_wen_o=1, addr=5, data=0xDEADBEEF. Repeat with addr=0 -> reg_wen_o=0.
- Lu with scoreboard:
  - Issue lu to x7; next cycle set id_rs2_i=7 -> stall_o=1.
  - Present lu result {7, 0x12345678} with ex idle -> written the following cycle; stall_o=0 one cycle after the write.
- Priority and full:
  - With ex_active every cycle, push 2 lu results ({3,0x1},{4,0x2}) -> lu_ready_o=0 after the second push, and the third result is held.
  - Drop ex -> x3 is written, then x4, in order. lu_ready_o rises the cycle after the first pop.
- Simultaneous events:
  - Pop of x9 in the same cycle as lu_issue_i to x9 -> pend[9] stays 1.
  - Push and pop in the same cycle at count=1 -> count stays 1.
- Mid-operation reset: 2 entries buffered with pend[3] and pend[4] set, then rst=0 for 1 cycle -> no writes occur, pend is cleared, and the FIFO is empty.
